fp32_accum_seq: RTL
===================

Name: fp32_accum_seq

Overview:
- Sequencer directly upstream of the multi-cycle fp32 adder; it also consumes the adder's result.
- Accepts a stream of IEEE-754 single-precision values, grouped by a last flag, and reduces each group to one sum by driving the adder iteratively.
- The adder's start input (its reset port) is pulsed once per addition. Operands are held stable until done.
- Presents the group sum on a valid/ready output to the downstream consumer.

Parameters:
- COUNT_W, 8, width of the per-group element counter; the count saturates at 2^COUNT_W-1.
- TIMEOUT, 63, maximum WAIT cycles for add_done before the error path is taken.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input element valid.
- in_data  in  32  fp32 element.
- in_last  in  1  element is the last of its group.
- in_ready  out  1  sequencer can accept an element.
- add_x  out  32  adder operand X (running sum).
- add_y  out  32  adder operand Y (new element).
- add_start  out  1  one-cycle start pulse; connects to the adder's reset port.
- add_z  in  32  adder result.
- add_done  in  1  adder completion flag.
- sum_valid  out  1  group sum available.
- sum_data  out  32  group sum.
- sum_count  out  COUNT_W  number of elements in the group.
- sum_err  out  1  sum is invalid because of an adder timeout; qualified by sum_valid.
- sum_ready  in  1  downstream accepts the sum.

Behaviour:
- Reset: state IDLE; all outputs 0 (in_ready=0 during the reset cycle, 1 from the first cycle after reset); acc, count and timer cleared.
- An element transfer occurs when in_valid & in_ready on a rising edge. A sum transfer occurs when sum_valid & sum_ready.
- IDLE (in_ready=1):
  - On transfer: acc<=in_data exactly (no addition, so the sign of zero is preserved) and count<=1.
  - If in_last: go to OUT. Otherwise go to ACC.
- ACC (in_ready=1):
  - On transfer: add_y<=in_data, add_x<=acc, count<=count+1 (saturating), last flag latched; go to ISSUE.
- ISSUE (in_ready=0):
  - add_start=1 for exactly this cycle; timer<=0; go to WAIT.
- WAIT (in_ready=0, add_start=0):
  - add_done is ignored in the first WAIT cycle, because the adder may still show done from the previous operation. It is honoured from the second WAIT cycle on.
  - On add_done: acc<=add_z. If the latched last flag is set, go to OUT; otherwise go to ACC.
  - If the timer reaches TIMEOUT without add_done: set the error flag and go to OUT with the current acc.
- OUT (in_ready=0):
  - sum_valid=1; sum_data, sum_count and sum_err are held stable until sum_ready.
  - On transfer: clear the error flag and count; go to IDLE.
- Latency:
  - Single-element group: sum_valid one cycle after the input transfer.
  - N elements: (N-1) x (adder latency + 2) + 1 cycles.
- add_x and add_y are constant from ISSUE until leaving WAIT, and hold their last value otherwise.
- No arithmetic is performed in this block. NaN and Inf pass through the adder untouched.
- in_last arriving in ACC closes the group after that element's addition.
- reset asserted in any state, including mid-WAIT, returns to IDLE in the same edge. An in-flight adder result is discarded, and add_start is not re-asserted.
- Simultaneous sum_ready with a new in_valid while in OUT: the input is not accepted until IDLE; there is no bypass.

Decomposition:
- Shared package fp32_acc_pkg holds:
  - the state enum (IDLE, ACC, ISSUE, WAIT, OUT);
  - FP32_ZERO = 32'h0000_0000;
  - the fp32 field-width constants (sign 1, exponent 8, mantissa 23).
- No sub-module is needed. The timeout counter is inline.

Test Plan:
- Group {1.0 = 3F800000, 2.0 = 40000000, 3.0 = 40400000 last} against the real adder -> single sum_valid with sum_data = 40C00000, sum_count = 3, sum_err = 0; exactly two add_start pulses.
- Group {0.8 = 3F4CCCCD, -0.7 = BF333333 last} -> sum_data = 3DCCCCD0, count = 2; add_x and add_y stable throughout WAIT.
- Single element 80000000 (-0.0) with last -> sum_data = 80000000, count = 1, no add_start, sum_valid on the next cycle.
- Adder model that never asserts done -> sum_valid after TIMEOUT+2 cycles from start with sum_err = 1; the next group then processes normally with sum_err = 0.
- Hold sum_ready low for 10 cycles in OUT -> sum_* stable, in_ready = 0, no element lost once sum_ready rises.
- Assert reset during WAIT -> next cycle IDLE, all outputs 0 except in_ready = 1; a late add_done is ignored.

Source files
------------

// File: rtl/fp32_acc_pkg.sv
// fp32_acc_pkg: shared state encoding and fp32 constants for the accumulation sequencer
package fp32_acc_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ACC, S_ISSUE, S_WAIT, S_OUT} state_t;
  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
  localparam int FP32_SIGN_W = 1;
  localparam int FP32_EXP_W = 8;
  localparam int FP32_MAN_W = 23;
endpackage

// File: rtl/fp32_accum_seq.sv
// fp32_accum_seq: reduces each last-delimited fp32 group to one sum by driving an external multi-cycle adder
module fp32_accum_seq
  import fp32_acc_pkg::*;
#(
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 63
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [31:0]        in_data,
  input  logic               in_last,
  output logic               in_ready,
  output logic [31:0]        add_x,
  output logic [31:0]        add_y,
  output logic               add_start,
  input  logic [31:0]        add_z,
  input  logic               add_done,
  output logic               sum_valid,
  output logic [31:0]        sum_data,
  output logic [COUNT_W-1:0] sum_count,
  output logic               sum_err,
  input  logic               sum_ready
);
  localparam int TW = $clog2(TIMEOUT + 1);
  state_t             r_state;
  logic [31:0]        r_acc, r_x, r_y;
  logic [COUNT_W-1:0] r_count;
  logic [TW-1:0]      r_timer;
  logic               r_last, r_err;
  logic               w_in_xfer, w_out_xfer;
  assign in_ready   = !reset && (r_state == S_IDLE || r_state == S_ACC);
  assign add_start  = !reset && r_state == S_ISSUE;
  assign sum_valid  = !reset && r_state == S_OUT;
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = sum_valid && sum_ready;
  assign add_x      = r_x;
  assign add_y      = r_y;
  assign sum_data   = r_acc;
  assign sum_count  = r_count;
  assign sum_err    = r_err;
  // Sequencer: the first element seeds acc directly, each later one is one adder round trip;
  // done is ignored while the timer is 0 because the adder may still show the previous done.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_acc   <= FP32_ZERO;
      r_x     <= FP32_ZERO;
      r_y     <= FP32_ZERO;
      r_count <= '0;
      r_timer <= '0;
      r_last  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_in_xfer) begin
          r_acc   <= in_data;
          r_count <= COUNT_W'(1);
          r_state <= in_last ? S_OUT : S_ACC;
        end
        S_ACC: if (w_in_xfer) begin
          r_y     <= in_data;
          r_x     <= r_acc;
          r_count <= (&r_count) ? r_count : r_count + COUNT_W'(1);
          r_last  <= in_last;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (add_done && r_timer != '0) begin
          r_acc   <= add_z;
          r_state <= r_last ? S_OUT : S_ACC;
        end else if (r_timer == TW'(TIMEOUT)) begin
          r_err   <= 1'b1;
          r_state <= S_OUT;
        end else begin
          r_timer <= r_timer + TW'(1);
        end
        S_OUT: if (w_out_xfer) begin
          r_err   <= 1'b0;
          r_count <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
